fsm_seq_engine: RTL and testbench

//  Parametrised start/ready sequence engine; next generation of the 5-bit single-shot FSM top.

---
 rtl/fsm_seq_pkg.sv | 15 +
 rtl/fib_datapath.sv | 50 +++++
 rtl/fsm_seq_engine.sv | 136 +++++++++++++
 tb/tb_fsm_seq_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the Fibonacci sequence engine.
//   state_t : control FSM states (IDLE, LOAD, RUN, DONE)
//   STATE_W : width of the state register
package fsm_seq_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fib_datapath.sv
// Iterative Fibonacci datapath: a/b pair, remaining-step counter k, adder.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   load            : k <= k_init, a <= 0, b <= 1
//   step            : a <= b, b <= a+b (mod 2^W), k <= k-1
//   k_init          : iteration count to latch on load
//   a_next          : value a will hold after this edge (final result tap)
//   k_is_one        : k == 1 (this step is the last one)
//   k_is_zero       : k == 0 (zero-length run)
module fib_datapath #(
   parameter int unsigned W   = 5,
   parameter int unsigned N_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [N_W-1:0] k_init,
   output logic [W-1:0]   a_next,
   output logic           k_is_one,
   output logic           k_is_zero
);

   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [N_W-1:0] k;

   // a/b are seeded together with k when the start is accepted, so they are
   // already 0/1 throughout the LOAD state and need no separate LOAD strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a <= '0;
         b <= W'(1);
         k <= '0;
      end else if (load) begin
         a <= '0;
         b <= W'(1);
         k <= k_init;
      end else if (step) begin
         a <= b;
         b <= a + b;
         k <= k - N_W'(1);
      end
   end

   assign a_next    = step ? b : a;
   assign k_is_one  = (k == N_W'(1));
   assign k_is_zero = (k == '0);

endmodule

// File: rtl/fsm_seq_engine.sv
// Start/ready sequence engine computing F(n_iter) mod 2^W, one step per clock.
// Ports:
//   clk_p     : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : level request, sampled in IDLE only
//   abort     : cancels a run in LOAD/RUN
//   n_iter    : iteration count, latched on accepted start
//   expected  : reference result, latched on accepted start
//   out       : F(n_iter) mod 2^W of the last completed run
//   ready     : high in DONE only
//   busy      : high in LOAD and RUN
//   correct   : out matched the latched expected value
//   cycles    : LOAD+RUN cycles of the last run, saturating
module fsm_seq_engine
   import fsm_seq_pkg::*;
#(
   parameter int unsigned W     = 5,
   parameter int unsigned N_W   = 6,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_p,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [N_W-1:0]   n_iter,
   input  logic [W-1:0]     expected,
   output logic [W-1:0]     out,
   output logic             ready,
   output logic             busy,
   output logic             correct,
   output logic [CNT_W-1:0] cycles
);

   state_t           state;
   state_t           state_nx;
   logic             accept;
   logic             dp_step;
   logic             finish;
   logic [W-1:0]     a_next;
   logic             k_is_one;
   logic             k_is_zero;
   logic [W-1:0]     exp_q;
   logic [W-1:0]     out_q;
   logic             correct_q;
   logic [CNT_W-1:0] cycles_q;

   fib_datapath #(
      .W   (W),
      .N_W (N_W)
   ) u_dp (
      .clk       (clk_p),
      .rst_n     (reset_n),
      .load      (accept),
      .step      (dp_step),
      .k_init    (n_iter),
      .a_next    (a_next),
      .k_is_one  (k_is_one),
      .k_is_zero (k_is_zero)
   );

   // Abort takes priority over completion; an aborted RUN cycle does not step.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      dp_step  = 1'b0;
      finish   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else if (k_is_zero) begin
               finish   = 1'b1;
               state_nx = S_DONE;
            end else begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else begin
               dp_step = 1'b1;
               if (k_is_one) begin
                  finish   = 1'b1;
                  state_nx = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!start) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_p or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         exp_q     <= '0;
         out_q     <= '0;
         correct_q <= 1'b0;
         cycles_q  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            exp_q    <= expected;
            cycles_q <= '0;
         end
         if (state == S_LOAD) begin
            cycles_q <= CNT_W'(1);
         end
         if (dp_step) begin
            cycles_q <= (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
         end
         if (finish) begin
            out_q     <= a_next;
            correct_q <= (a_next == exp_q);
         end
      end
   end

   assign out     = out_q;
   assign correct = correct_q;
   assign cycles  = cycles_q;
   assign ready   = (state == S_DONE);
   assign busy    = (state == S_LOAD) || (state == S_RUN);

endmodule

// File: tb/tb_fsm_seq_engine.sv
module tb_fsm_seq_engine;

   localparam int unsigned W     = 5;
   localparam int unsigned N_W   = 6;
   localparam int unsigned CNT_W = 16;

   logic             clk_p    = 1'b0;
   logic             reset_n  = 1'b1;
   logic             start    = 1'b0;
   logic             abort    = 1'b0;
   logic [N_W-1:0]   n_iter   = '0;
   logic [W-1:0]     expected = '0;

   logic [W-1:0]     out,   out4;
   logic             ready, ready4;
   logic             busy,  busy4;
   logic             correct, correct4;
   logic [CNT_W-1:0] cycles;
   logic [3:0]       cycles4;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned last_out = 0;
   bit          last_correct = 1'b0;

   fsm_seq_engine #(.W(W), .N_W(N_W), .CNT_W(CNT_W)) dut (
      .clk_p(clk_p), .reset_n(reset_n), .start(start), .abort(abort),
      .n_iter(n_iter), .expected(expected), .out(out), .ready(ready),
      .busy(busy), .correct(correct), .cycles(cycles)
   );

   fsm_seq_engine #(.W(W), .N_W(N_W), .CNT_W(4)) dut_sat (
      .clk_p(clk_p), .reset_n(reset_n), .start(start), .abort(abort),
      .n_iter(n_iter), .expected(expected), .out(out4), .ready(ready4),
      .busy(busy4), .correct(correct4), .cycles(cycles4)
   );

   always #5 clk_p = ~clk_p;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: F(n) mod 2^W by plain iteration on integers.
   function automatic int unsigned fib_mod(input int unsigned n);
      int unsigned x = 0, y = 1, t;
      for (int unsigned i = 0; i < n; i++) begin
         t = (x + y) % (1 << W);
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int unsigned sat15(input int unsigned v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_p);
      #1;
   endtask

   // Issues one start; returns edges from the accept edge (inclusive) to the
   // edge after which ready was seen, or stops when busy drops (abort).
   // abort_j>0 aborts on the abort_j-th RUN edge.
   task automatic run_once(input int unsigned n, input int unsigned e,
                           input int unsigned abort_j, input bit hold,
                           output int unsigned lat, output bit seen);
      start = 1'b0;
      tick();
      tick();
      start    = 1'b1;
      n_iter   = N_W'(n);
      expected = W'(e);
      tick();
      lat  = 1;
      seen = 1'b0;
      if (!hold) start = 1'b0;
      n_iter   = N_W'($urandom);
      expected = W'($urandom);
      while (lat < n + 10) begin
         if (abort_j != 0 && lat == abort_j + 1) abort = 1'b1;
         tick();
         lat++;
         abort = 1'b0;
         if (ready) begin
            seen = 1'b1;
            break;
         end
         if (!busy) break;
      end
   endtask

   task automatic check_done(input string tag, input int unsigned lat, input bit seen,
                             input int unsigned n, input int unsigned xo, input bit xc,
                             input int unsigned xcyc, input int unsigned xcyc4);
      check($sformatf("%s.ready", tag), 64'(seen), 64'(1));
      check($sformatf("%s.ready4", tag), 64'(ready4), 64'(1));
      check($sformatf("%s.latency", tag), 64'(lat), 64'(n + 2));
      check($sformatf("%s.out", tag), 64'(out), 64'(xo));
      check($sformatf("%s.out4", tag), 64'(out4), 64'(xo));
      check($sformatf("%s.correct", tag), 64'(correct), 64'(xc));
      check($sformatf("%s.correct4", tag), 64'(correct4), 64'(xc));
      check($sformatf("%s.cycles", tag), 64'(cycles), 64'(xcyc));
      check($sformatf("%s.cycles4", tag), 64'(cycles4), 64'(xcyc4));
      last_out     = xo;
      last_correct = xc;
   endtask

   task automatic check_abort(input string tag, input bit seen, input int unsigned j);
      check($sformatf("%s.no_ready", tag), 64'(seen), 64'(0));
      check($sformatf("%s.busy", tag), 64'(busy), 64'(0));
      check($sformatf("%s.busy4", tag), 64'(busy4), 64'(0));
      check($sformatf("%s.out", tag), 64'(out), 64'(last_out));
      check($sformatf("%s.correct", tag), 64'(correct), 64'(last_correct));
      check($sformatf("%s.cycles", tag), 64'(cycles), 64'(j));
      check($sformatf("%s.cycles4", tag), 64'(cycles4), 64'(sat15(j)));
   endtask

   typedef struct {
      int unsigned n;
      int unsigned e;
      int unsigned xo;
      bit          xc;
      int unsigned xcyc;
      int unsigned xcyc4;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int unsigned lat, n, e, j, xo, drops, rises;
      bit          seen, prev;

      tbl[0] = '{n:10, e:23, xo:23, xc:1'b1, xcyc:11, xcyc4:11};
      tbl[1] = '{n:0,  e:0,  xo:0,  xc:1'b1, xcyc:1,  xcyc4:1};
      tbl[2] = '{n:1,  e:1,  xo:1,  xc:1'b1, xcyc:2,  xcyc4:2};
      tbl[3] = '{n:7,  e:12, xo:13, xc:1'b0, xcyc:8,  xcyc4:8};
      tbl[4] = '{n:7,  e:13, xo:13, xc:1'b1, xcyc:8,  xcyc4:8};
      tbl[5] = '{n:2,  e:0,  xo:1,  xc:1'b0, xcyc:3,  xcyc4:3};
      tbl[6] = '{n:3,  e:2,  xo:2,  xc:1'b1, xcyc:4,  xcyc4:4};
      tbl[7] = '{n:40, e:11, xo:11, xc:1'b1, xcyc:41, xcyc4:15};
      tbl[8] = '{n:63, e:2,  xo:2,  xc:1'b1, xcyc:64, xcyc4:15};

      // Reset state
      #2 reset_n = 1'b0;
      #1;
      check("rst.out", 64'(out), 64'(0));
      check("rst.ready", 64'(ready), 64'(0));
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.correct", 64'(correct), 64'(0));
      check("rst.cycles", 64'(cycles), 64'(0));
      @(posedge clk_p);
      @(posedge clk_p);
      #3 reset_n = 1'b1;

      // Held start: exactly one run, ready stays high while start is held
      run_once(tbl[0].n, tbl[0].e, 0, 1'b1, lat, seen);
      check_done("hold", lat, seen, tbl[0].n, tbl[0].xo, tbl[0].xc, tbl[0].xcyc, tbl[0].xcyc4);
      drops = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (!ready || busy) drops++;
      end
      check("hold.single_run", 64'(drops), 64'(0));
      start = 1'b0;

      foreach (tbl[i]) begin
         run_once(tbl[i].n, tbl[i].e, 0, 1'b0, lat, seen);
         check_done($sformatf("vec%0d", i), lat, seen, tbl[i].n, tbl[i].xo, tbl[i].xc,
                    tbl[i].xcyc, tbl[i].xcyc4);
      end

      // Abort on the 5th RUN cycle of a 20-step run
      run_once(20, 3, 5, 1'b0, lat, seen);
      check_abort("abort", seen, 5);
      rises = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ready || busy) rises++;
      end
      check("abort.quiet", 64'(rises), 64'(0));

      // Asynchronous reset mid-RUN
      start = 1'b0;
      tick();
      start  = 1'b1;
      n_iter = N_W'(20);
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("rstmid.busy_before", 64'(busy), 64'(1));
      #2 reset_n = 1'b0;
      #1;
      check("rstmid.out", 64'(out), 64'(0));
      check("rstmid.busy", 64'(busy), 64'(0));
      check("rstmid.ready", 64'(ready), 64'(0));
      check("rstmid.correct", 64'(correct), 64'(0));
      check("rstmid.cycles", 64'(cycles), 64'(0));
      check("rstmid.cycles4", 64'(cycles4), 64'(0));
      #1 reset_n = 1'b1;
      last_out     = 0;
      last_correct = 1'b0;
      run_once(10, 23, 0, 1'b0, lat, seen);
      check_done("rstmid.rerun", lat, seen, 10, 23, 1'b1, 11, 11);

      // Randomized runs against the reference model
      for (int i = 0; i < 40; i++) begin
         n  = $urandom_range(0, 45);
         xo = fib_mod(n);
         e  = ($urandom_range(0, 1) == 0) ? xo : $urandom_range(0, 31);
         j  = (n >= 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
         run_once(n, e, j, 1'b0, lat, seen);
         if (j != 0) begin
            check_abort($sformatf("rnd%0d.abort", i), seen, j);
         end else begin
            check_done($sformatf("rnd%0d", i), lat, seen, n, xo, (xo == e),
                       n + 1, sat15(n + 1));
         end
      end

      prev = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
